// File: rtl/ld_nn_phase_sequencer.sv
// Phase sequencer for direct-address loads and stores: LD r,(nn) / LD rr,(nn) / LD (nn),r / LD (nn),rr.
// Fetches the two operand bytes via PC, moves 1..2 data bytes at nn/nn+1, then hands back to M1.
module ld_nn_phase_sequencer #(
    parameter int DATA_BYTES = 1,
    parameter int XPT_W      = 4,
    parameter int XPT_BASE   = 3
) (
    input  logic             CLK,
    input  logic             notRESET,
    input  logic             start,
    input  logic             is_store,
    input  logic [15:0]      store_data,
    input  logic             abort,
    input  logic             mem_ready,
    input  logic [7:0]       mem_data_in,
    output logic             addr_sel_pc,
    output logic [15:0]      addr_out,
    output logic             mem_rd,
    output logic             mem_wr,
    output logic [7:0]       mem_data_out,
    output logic             pc_incr,
    output logic [XPT_W-1:0] xpt,
    output logic             busy,
    output logic             reg_write,
    output logic [15:0]      reg_data,
    output logic             set_cm1
);

    typedef enum logic [2:0] {
        IDLE,
        OPL,
        OPH,
        XFER,
        DONE
    } state_t;

    localparam logic [XPT_W-1:0] XPT_OPL   = XPT_W'(XPT_BASE);
    localparam logic [XPT_W-1:0] XPT_OPH   = XPT_W'(XPT_BASE + 1);
    localparam logic [XPT_W-1:0] XPT_XFER0 = XPT_W'(XPT_BASE + 2);
    localparam logic [XPT_W-1:0] XPT_DONE  = XPT_W'(XPT_BASE + 2 + DATA_BYTES);
    localparam logic             LAST_IDX  = (DATA_BYTES == 2) ? 1'b1 : 1'b0;

    state_t      state;
    logic        byte_idx;
    logic [7:0]  nn_lo;
    logic        store_flag;
    logic [15:0] store_word;
    logic [7:0]  load_lo;

    // The PC only advances when an operand byte is actually accepted; abort suppresses it.
    assign pc_incr = ((state == OPL) || (state == OPH)) && mem_ready && !abort;

    // All other outputs are registered and set up for the state being entered.
    always_ff @(posedge CLK or negedge notRESET) begin
        if (!notRESET) begin
            state        <= IDLE;
            byte_idx     <= 1'b0;
            nn_lo        <= 8'h00;
            store_flag   <= 1'b0;
            store_word   <= 16'h0000;
            load_lo      <= 8'h00;
            addr_sel_pc  <= 1'b0;
            addr_out     <= 16'h0000;
            mem_rd       <= 1'b0;
            mem_wr       <= 1'b0;
            mem_data_out <= 8'h00;
            xpt          <= '0;
            busy         <= 1'b0;
            reg_write    <= 1'b0;
            reg_data     <= 16'h0000;
            set_cm1      <= 1'b0;
        end else if ((state != IDLE) && abort) begin
            state        <= IDLE;
            byte_idx     <= 1'b0;
            addr_sel_pc  <= 1'b0;
            addr_out     <= 16'h0000;
            mem_rd       <= 1'b0;
            mem_wr       <= 1'b0;
            mem_data_out <= 8'h00;
            xpt          <= '0;
            busy         <= 1'b0;
            reg_write    <= 1'b0;
            set_cm1      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start && !abort) begin
                        store_flag  <= is_store;
                        store_word  <= store_data;
                        state       <= OPL;
                        xpt         <= XPT_OPL;
                        addr_sel_pc <= 1'b1;
                        mem_rd      <= 1'b1;
                        busy        <= 1'b1;
                    end
                end
                OPL: begin
                    if (mem_ready) begin
                        nn_lo <= mem_data_in;
                        state <= OPH;
                        xpt   <= XPT_OPH;
                    end
                end
                OPH: begin
                    if (mem_ready) begin
                        addr_out     <= {mem_data_in, nn_lo};
                        byte_idx     <= 1'b0;
                        state        <= XFER;
                        xpt          <= XPT_XFER0;
                        addr_sel_pc  <= 1'b0;
                        mem_rd       <= !store_flag;
                        mem_wr       <= store_flag;
                        mem_data_out <= store_flag ? store_word[7:0] : 8'h00;
                    end
                end
                XFER: begin
                    if (mem_ready) begin
                        if (byte_idx == LAST_IDX) begin
                            state        <= DONE;
                            xpt          <= XPT_DONE;
                            addr_out     <= 16'h0000;
                            mem_rd       <= 1'b0;
                            mem_wr       <= 1'b0;
                            mem_data_out <= 8'h00;
                            set_cm1      <= 1'b1;
                            if (!store_flag) begin
                                reg_write <= 1'b1;
                                if (DATA_BYTES == 1) begin
                                    reg_data <= {8'h00, mem_data_in};
                                end else begin
                                    reg_data <= {mem_data_in, load_lo};
                                end
                            end
                        end else begin
                            // Address wraps naturally from 0xFFFF to 0x0000.
                            load_lo      <= mem_data_in;
                            byte_idx     <= 1'b1;
                            addr_out     <= addr_out + 16'd1;
                            xpt          <= xpt + XPT_W'(1);
                            mem_data_out <= store_flag ? store_word[15:8] : 8'h00;
                        end
                    end
                end
                DONE: begin
                    state     <= IDLE;
                    xpt       <= '0;
                    busy      <= 1'b0;
                    reg_write <= 1'b0;
                    set_cm1   <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    xpt   <= '0;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ld_nn_phase_sequencer.sv
// Self-checking bench: a 1-byte and a 2-byte sequencer share stimulus, each tracked by a step-count model.
module tb_ld_nn_phase_sequencer;

    logic        CLK;
    logic        notRESET;
    logic        start;
    logic        is_store;
    logic [15:0] store_data;
    logic        abort;
    logic        mem_ready;
    logic [7:0]  mem_data_in;

    logic        addr_sel_pc_o  [2];
    logic [15:0] addr_out_o     [2];
    logic        mem_rd_o       [2];
    logic        mem_wr_o       [2];
    logic [7:0]  mem_data_out_o [2];
    logic        pc_incr_o      [2];
    logic [3:0]  xpt_o          [2];
    logic        busy_o         [2];
    logic        reg_write_o    [2];
    logic [15:0] reg_data_o     [2];
    logic        set_cm1_o      [2];

    int total = 0;
    int bad = 0;
    int cycle = 0;

    bit          m_active [2];
    int          m_k      [2];
    logic [15:0] m_nn     [2];
    bit          m_st     [2];
    logic [15:0] m_sd     [2];
    logic [7:0]  m_bytes  [2][2];
    logic [15:0] m_reg    [2];

    int xtr [2][$];
    int pc_count   [2];
    int rw_count   [2];
    int cm1_count  [2];
    int busy_count [2];

    ld_nn_phase_sequencer #(.DATA_BYTES(1), .XPT_W(4), .XPT_BASE(3)) u_db1 (
        .CLK(CLK), .notRESET(notRESET), .start(start), .is_store(is_store),
        .store_data(store_data), .abort(abort), .mem_ready(mem_ready), .mem_data_in(mem_data_in),
        .addr_sel_pc(addr_sel_pc_o[0]), .addr_out(addr_out_o[0]), .mem_rd(mem_rd_o[0]),
        .mem_wr(mem_wr_o[0]), .mem_data_out(mem_data_out_o[0]), .pc_incr(pc_incr_o[0]),
        .xpt(xpt_o[0]), .busy(busy_o[0]), .reg_write(reg_write_o[0]),
        .reg_data(reg_data_o[0]), .set_cm1(set_cm1_o[0])
    );

    ld_nn_phase_sequencer #(.DATA_BYTES(2), .XPT_W(4), .XPT_BASE(3)) u_db2 (
        .CLK(CLK), .notRESET(notRESET), .start(start), .is_store(is_store),
        .store_data(store_data), .abort(abort), .mem_ready(mem_ready), .mem_data_in(mem_data_in),
        .addr_sel_pc(addr_sel_pc_o[1]), .addr_out(addr_out_o[1]), .mem_rd(mem_rd_o[1]),
        .mem_wr(mem_wr_o[1]), .mem_data_out(mem_data_out_o[1]), .pc_incr(pc_incr_o[1]),
        .xpt(xpt_o[1]), .busy(busy_o[1]), .reg_write(reg_write_o[1]),
        .reg_data(reg_data_o[1]), .set_cm1(set_cm1_o[1])
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("[TB] FAIL %s cycle=%0d got=%h want=%h", tag, cycle, got, want);
        end
    endtask

    task automatic resetModel();
        for (int n = 0; n < 2; n++) begin
            m_active[n] = 1'b0;
            m_k[n]      = 0;
            m_nn[n]     = 16'h0000;
            m_st[n]     = 1'b0;
            m_sd[n]     = 16'h0000;
            m_reg[n]    = 16'h0000;
        end
    endtask

    task automatic clearStats();
        for (int n = 0; n < 2; n++) begin
            xtr[n].delete();
            pc_count[n]   = 0;
            rw_count[n]   = 0;
            cm1_count[n]  = 0;
            busy_count[n] = 0;
        end
    endtask

    function automatic bit inDone(input int n);
        return m_active[n] && (m_k[n] == 3 + n);
    endfunction

    // Expected outputs follow from how many phases of the transaction have completed.
    task automatic compareInstance(input int n);
        int db;
        bit xf;
        bit dn;
        logic [15:0] want_addr;
        logic [7:0]  want_dout;
        db = n + 1;
        xf = m_active[n] && (m_k[n] >= 2) && (m_k[n] < 2 + db);
        dn = m_active[n] && (m_k[n] == 2 + db);
        checkOutput($sformatf("u%0d_busy", db), 32'(busy_o[n]), 32'(m_active[n]));
        checkOutput($sformatf("u%0d_xpt", db), 32'(xpt_o[n]), m_active[n] ? 32'(3 + m_k[n]) : 32'd0);
        checkOutput($sformatf("u%0d_selpc", db), 32'(addr_sel_pc_o[n]), 32'(m_active[n] && m_k[n] < 2));
        checkOutput($sformatf("u%0d_rd", db), 32'(mem_rd_o[n]),
                    32'(m_active[n] && (m_k[n] < 2 || (xf && !m_st[n]))));
        checkOutput($sformatf("u%0d_wr", db), 32'(mem_wr_o[n]), 32'(xf && m_st[n]));
        checkOutput($sformatf("u%0d_pcinc", db), 32'(pc_incr_o[n]),
                    32'(m_active[n] && m_k[n] < 2 && mem_ready && !abort));
        checkOutput($sformatf("u%0d_rw", db), 32'(reg_write_o[n]), 32'(dn && !m_st[n]));
        checkOutput($sformatf("u%0d_cm1", db), 32'(set_cm1_o[n]), 32'(dn));
        checkOutput($sformatf("u%0d_rdata", db), 32'(reg_data_o[n]), 32'(m_reg[n]));
        if (!m_active[n] || xf) begin
            want_addr = xf ? 16'(m_nn[n] + 16'(m_k[n] - 2)) : 16'h0000;
            checkOutput($sformatf("u%0d_addr", db), 32'(addr_out_o[n]), 32'(want_addr));
        end
        if (!m_active[n] || (xf && m_st[n])) begin
            want_dout = !m_active[n] ? 8'h00 : ((m_k[n] == 2) ? m_sd[n][7:0] : m_sd[n][15:8]);
            checkOutput($sformatf("u%0d_dout", db), 32'(mem_data_out_o[n]), 32'(want_dout));
        end
    endtask

    task automatic modelStep(input int n);
        int db;
        db = n + 1;
        if (!m_active[n]) begin
            if (start && !abort) begin
                m_active[n] = 1'b1;
                m_k[n]      = 0;
                m_st[n]     = is_store;
                m_sd[n]     = store_data;
            end
        end else if (abort) begin
            m_active[n] = 1'b0;
        end else if (m_k[n] == 2 + db) begin
            m_active[n] = 1'b0;
        end else if (mem_ready) begin
            if (m_k[n] == 0) m_nn[n][7:0] = mem_data_in;
            else if (m_k[n] == 1) m_nn[n][15:8] = mem_data_in;
            else if (!m_st[n]) m_bytes[n][m_k[n] - 2] = mem_data_in;
            m_k[n]++;
            if (m_k[n] == 2 + db && !m_st[n])
                m_reg[n] = (db == 1) ? {8'h00, m_bytes[n][0]} : {m_bytes[n][1], m_bytes[n][0]};
        end
    endtask

    // Called just after a rising edge; drives one cycle of inputs and checks both units mid-cycle.
    task automatic applyStimulus(input logic s, input logic st, input logic [15:0] sd,
                                 input logic ab, input logic rdy, input logic [7:0] din);
        start       = s;
        is_store    = st;
        store_data  = sd;
        abort       = ab;
        mem_ready   = rdy;
        mem_data_in = din;
        @(negedge CLK);
        for (int n = 0; n < 2; n++) begin
            compareInstance(n);
            xtr[n].push_back(int'(xpt_o[n]));
            if (pc_incr_o[n])   pc_count[n]++;
            if (reg_write_o[n]) rw_count[n]++;
            if (set_cm1_o[n])   cm1_count[n]++;
            if (busy_o[n])      busy_count[n]++;
        end
        for (int n = 0; n < 2; n++) modelStep(n);
        @(posedge CLK);
        #1;
        cycle++;
    endtask

    task automatic checkResetOutputs(input string tag);
        for (int n = 0; n < 2; n++) begin
            checkOutput($sformatf("%s_u%0d_busy", tag, n + 1), 32'(busy_o[n]), 32'd0);
            checkOutput($sformatf("%s_u%0d_xpt", tag, n + 1), 32'(xpt_o[n]), 32'd0);
            checkOutput($sformatf("%s_u%0d_addr", tag, n + 1), 32'(addr_out_o[n]), 32'd0);
            checkOutput($sformatf("%s_u%0d_rdwr", tag, n + 1),
                        32'({mem_rd_o[n], mem_wr_o[n], addr_sel_pc_o[n], pc_incr_o[n]}), 32'd0);
            checkOutput($sformatf("%s_u%0d_dout", tag, n + 1), 32'(mem_data_out_o[n]), 32'd0);
            checkOutput($sformatf("%s_u%0d_rdata", tag, n + 1), 32'(reg_data_o[n]), 32'd0);
            checkOutput($sformatf("%s_u%0d_strobes", tag, n + 1),
                        32'({reg_write_o[n], set_cm1_o[n]}), 32'd0);
        end
    endtask

    task automatic asyncReset();
        start     = 1'b0;
        abort     = 1'b0;
        mem_ready = 1'b0;
        #2;
        notRESET = 1'b0;
        #1;
        checkResetOutputs("areset");
        resetModel();
        @(negedge CLK);
        notRESET = 1'b1;
        @(posedge CLK);
        #1;
        cycle++;
    endtask

    task automatic checkTrace(input string tag, input int n, input int want[], input int len);
        checkOutput($sformatf("%s_len", tag), 32'(xtr[n].size()), 32'(len));
        for (int i = 0; i < len && i < xtr[n].size(); i++)
            checkOutput($sformatf("%s_%0d", tag, i), 32'(xtr[n][i]), 32'(want[i]));
    endtask

    initial begin
        int t1x[];
        int t2x[];
        int t3x[];
        logic s, st, ab, rdy;
        logic [15:0] sd;
        logic [7:0] din;

        notRESET    = 1'b0;
        start       = 1'b0;
        is_store    = 1'b0;
        store_data  = 16'h0000;
        abort       = 1'b0;
        mem_ready   = 1'b0;
        mem_data_in = 8'h00;
        resetModel();
        clearStats();
        #12;
        checkResetOutputs("reset");
        @(negedge CLK);
        notRESET = 1'b1;
        @(posedge CLK);
        #1;

        $display("[TB] load, no waits");
        clearStats();
        applyStimulus(1, 0, 16'h0000, 0, 1, 8'h00);
        applyStimulus(0, 0, 16'h0000, 0, 1, 8'h34);
        applyStimulus(0, 0, 16'h0000, 0, 1, 8'h12);
        applyStimulus(0, 0, 16'h0000, 0, 1, 8'h5A);
        applyStimulus(0, 0, 16'h0000, 0, 1, 8'h77);
        applyStimulus(0, 0, 16'h0000, 0, 1, 8'h00);
        t1x = '{0, 3, 4, 5, 6, 0};
        checkTrace("t1_xpt", 0, t1x, 6);
        checkOutput("t1_pcinc", 32'(pc_count[0]), 32'd2);
        checkOutput("t1_rw", 32'(rw_count[0]), 32'd1);
        checkOutput("t1_u1_rdata", 32'(reg_data_o[0]), 32'h005A);
        checkOutput("t1_u2_rdata", 32'(reg_data_o[1]), 32'h775A);

        $display("[TB] store at 0xFFFF with wrap");
        clearStats();
        applyStimulus(1, 1, 16'hBEEF, 0, 1, 8'h00);
        applyStimulus(0, 0, 16'h0000, 0, 1, 8'hFF);
        applyStimulus(0, 0, 16'h0000, 0, 1, 8'hFF);
        applyStimulus(0, 0, 16'h0000, 0, 1, 8'h00);
        applyStimulus(0, 0, 16'h0000, 0, 1, 8'h00);
        applyStimulus(0, 0, 16'h0000, 0, 1, 8'h00);
        applyStimulus(0, 0, 16'h0000, 0, 1, 8'h00);
        t2x = '{0, 3, 4, 5, 6, 7, 0};
        checkTrace("t2_xpt", 1, t2x, 7);
        checkOutput("t2_rw", 32'(rw_count[1]), 32'd0);
        checkOutput("t2_cm1", 32'(cm1_count[1]), 32'd1);
        checkOutput("t2_u2_rdata", 32'(reg_data_o[1]), 32'h775A);

        $display("[TB] wait states in OPH");
        clearStats();
        applyStimulus(1, 0, 16'h0000, 0, 1, 8'h00);
        applyStimulus(0, 0, 16'h0000, 0, 1, 8'h40);
        applyStimulus(0, 0, 16'h0000, 0, 0, 8'hEE);
        applyStimulus(0, 0, 16'h0000, 0, 0, 8'hEE);
        applyStimulus(0, 0, 16'h0000, 0, 1, 8'h20);
        applyStimulus(0, 0, 16'h0000, 0, 1, 8'h11);
        applyStimulus(0, 0, 16'h0000, 0, 1, 8'h22);
        applyStimulus(0, 0, 16'h0000, 0, 1, 8'h00);
        applyStimulus(0, 0, 16'h0000, 0, 1, 8'h00);
        t3x = '{0, 3, 4, 4, 4, 5, 6, 0, 0};
        checkTrace("t3_xpt", 0, t3x, 9);
        checkOutput("t3_pcinc", 32'(pc_count[0]), 32'd2);
        checkOutput("t3_u1_rdata", 32'(reg_data_o[0]), 32'h0011);
        checkOutput("t3_u2_rdata", 32'(reg_data_o[1]), 32'h2211);

        $display("[TB] abort with mem_ready at first data byte");
        clearStats();
        applyStimulus(1, 0, 16'h0000, 0, 1, 8'h00);
        applyStimulus(0, 0, 16'h0000, 0, 1, 8'h00);
        applyStimulus(0, 0, 16'h0000, 0, 1, 8'h90);
        applyStimulus(0, 0, 16'h0000, 1, 1, 8'hC3);
        applyStimulus(0, 0, 16'h0000, 0, 1, 8'h00);
        applyStimulus(0, 0, 16'h0000, 0, 1, 8'h00);
        checkOutput("t4_rw", 32'(rw_count[1]), 32'd0);
        checkOutput("t4_cm1", 32'(cm1_count[1]), 32'd0);
        checkOutput("t4_xpt_after", 32'(xtr[1][4]), 32'd0);
        checkOutput("t4_u2_rdata", 32'(reg_data_o[1]), 32'h2211);

        $display("[TB] asynchronous reset mid transfer");
        applyStimulus(1, 1, 16'hBEEF, 0, 1, 8'h00);
        applyStimulus(0, 0, 16'h0000, 0, 1, 8'h00);
        applyStimulus(0, 0, 16'h0000, 0, 1, 8'h80);
        asyncReset();
        clearStats();
        applyStimulus(1, 0, 16'h0000, 0, 1, 8'h00);
        applyStimulus(0, 0, 16'h0000, 0, 1, 8'h10);
        applyStimulus(0, 0, 16'h0000, 0, 1, 8'h20);
        applyStimulus(0, 0, 16'h0000, 0, 1, 8'hA5);
        applyStimulus(0, 0, 16'h0000, 0, 1, 8'h5A);
        applyStimulus(0, 0, 16'h0000, 0, 1, 8'h00);
        applyStimulus(0, 0, 16'h0000, 0, 1, 8'h00);
        checkOutput("t5_u1_rdata", 32'(reg_data_o[0]), 32'h00A5);
        checkOutput("t5_u2_rdata", 32'(reg_data_o[1]), 32'h5AA5);
        checkOutput("t5_cm1", 32'(cm1_count[1]), 32'd1);

        $display("[TB] start while busy, start with abort in idle");
        clearStats();
        applyStimulus(1, 0, 16'h0000, 0, 0, 8'h00);
        applyStimulus(1, 1, 16'h1234, 0, 1, 8'h01);
        applyStimulus(1, 1, 16'h1234, 0, 1, 8'h02);
        applyStimulus(1, 1, 16'h1234, 0, 1, 8'h03);
        applyStimulus(1, 1, 16'h1234, 0, 1, 8'h04);
        applyStimulus(0, 0, 16'h0000, 0, 1, 8'h00);
        applyStimulus(1, 0, 16'h0000, 1, 1, 8'h00);
        applyStimulus(0, 0, 16'h0000, 0, 1, 8'h00);
        checkOutput("t6_u1_busy", 32'(busy_count[0]), 32'd4);
        checkOutput("t6_u2_busy", 32'(busy_count[1]), 32'd5);
        checkOutput("t6_u2_rdata", 32'(reg_data_o[1]), 32'h0403);

        $display("[TB] randomized traffic");
        for (int i = 0; i < 1500; i++) begin
            s   = ($urandom_range(0, 3) == 0);
            st  = 1'($urandom_range(0, 1));
            sd  = 16'($urandom);
            rdy = ($urandom_range(0, 3) != 0);
            din = 8'($urandom);
            ab  = ($urandom_range(0, 19) == 0) && !inDone(0) && !inDone(1);
            applyStimulus(s, st, sd, ab, rdy, din);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ld_nn_phase_sequencer.md
Name: ld_nn_phase_sequencer

Overview:
- Parametrised, clocked phase sequencer for direct-address transfers: LD r,(nn), LD rr,(nn), LD (nn),r and LD (nn),rr.
- It starts after the instruction decoder recognises the opcode.
- It owns its own XPT phase counter, fetches the two operand bytes (nn) via PC, then performs 1 or 2 data transfers at nn / nn+1.
- Each memory phase stretches with mem_ready wait states. The sequencer ends by raising set_cm1 to hand control back to the M1 fetch.

Parameters:
- DATA_BYTES, 1, number of data bytes transferred at nn (1 = 8-bit register, 2 = register pair); legal values 1..2.
- XPT_W, 4, width of the XPT phase counter.
- XPT_BASE, 3, XPT value of the first operand-fetch phase; BASE+2+DATA_BYTES must be less than 2^XPT_W.

Ports:
- CLK  in  1  system clock; all state changes on the rising edge.
- notRESET  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle request from the decoder; honoured only in IDLE.
- is_store  in  1  sampled with start; 1 = write to (nn), 0 = read from (nn).
- store_data  in  16  source register, sampled with start; low byte is transferred first.
- abort  in  1  synchronous abort; return to IDLE.
- mem_ready  in  1  high = current memory phase completes this cycle.
- mem_data_in  in  8  read data, valid when mem_ready=1.
- addr_sel_pc  out  1  1 = bus address comes from PC; 0 = bus address is addr_out.
- addr_out  out  16  data-transfer address (nn or nn+1).
- mem_rd  out  1  read request.
- mem_wr  out  1  write request.
- mem_data_out  out  8  write data.
- pc_incr  out  1  PC increment pulse, once per accepted operand byte.
- xpt  out  XPT_W  current phase number.
- busy  out  1  high in every state except IDLE.
- reg_write  out  1  one-cycle strobe that writes reg_data into the destination register (load only).
- reg_data  out  16  assembled load data.
- set_cm1  out  1  one-cycle strobe: next cycle is M1.

Behaviour:
- Reset (notRESET=0, asynchronous): state=IDLE. xpt, addr_out, reg_data, mem_data_out and all strobes go to 0 immediately. Latched nn, the store flag and store data are cleared.
- States: IDLE, OPL, OPH, XFER, DONE. The byte index i counts 0..DATA_BYTES-1 within XFER.
- IDLE:
  - Outputs 0, xpt=0.
  - start=1 with abort=0 latches is_store and store_data, then moves to OPL.
- OPL:
  - xpt=XPT_BASE, addr_sel_pc=1, mem_rd=1.
  - On mem_ready=1: latch mem_data_in as nn[7:0], pc_incr=1 (combinational, that cycle only), go to OPH.
- OPH:
  - xpt=BASE+1, addr_sel_pc=1, mem_rd=1.
  - On mem_ready=1: latch nn[15:8], pc_incr=1, go to XFER with i=0.
- XFER:
  - xpt=BASE+2+i, addr_sel_pc=0, addr_out = nn+i mod 2^16 (0xFFFF+1 wraps to 0x0000).
  - Load: mem_rd=1; on mem_ready, byte i of the result is taken from mem_data_in.
  - Store: mem_wr=1, mem_data_out = store_data byte i.
  - On mem_ready=1: if i = DATA_BYTES-1, go to DONE; otherwise increment i.
- DONE (exactly 1 cycle):
  - xpt=BASE+2+DATA_BYTES, set_cm1=1.
  - Load: reg_write=1 and reg_data = assembled bytes; the upper byte is 0 when DATA_BYTES=1.
  - Store: reg_write=0.
  - Next state IDLE.
- Wait states: while mem_ready=0, the state, xpt and all outputs hold. pc_incr does not pulse.
- Latency with no waits: start in cycle 0, DONE in cycle 3+DATA_BYTES, IDLE in the following cycle.
- Priorities:
  - abort over mem_ready over everything else.
  - abort in any busy state: IDLE next cycle, no reg_write, no set_cm1, xpt=0.
  - start while busy: ignored.
  - start and abort together in IDLE: stay IDLE.
- mem_rd and mem_wr are never high together. reg_write and set_cm1 fire only in DONE.
- reg_data holds its value until the next load reaches DONE, or until reset.

Test Plan:
- Load, DATA_BYTES=1, no waits, operands 0x34 then 0x12, data 0x5A -> xpt sequence 3,4,5,6,0; addr_out=0x1234 in cycle 3; reg_write=1 with reg_data=0x005A and set_cm1=1 in cycle 4; pc_incr high in cycles 1 and 2 only.
- Store, DATA_BYTES=2, nn=0xFFFF, store_data=0xBEEF -> write 0xEF at 0xFFFF (xpt=5), write 0xBE at 0x0000 (xpt=6); DONE at xpt=7 with reg_write=0 and set_cm1=1.
- mem_ready low for 2 cycles during OPH -> xpt holds at 4 for 3 cycles; exactly one pc_incr pulse; total latency grows by 2.
- Load, DATA_BYTES=2, abort asserted in the same cycle as mem_ready at i=0 -> IDLE next cycle, xpt=0, no reg_write, no set_cm1, reg_data unchanged.
- notRESET pulled low mid-XFER, asynchronous to CLK -> all outputs 0 before the next edge; after release, a new start runs a full sequence correctly.
- start pulsed while busy, and start together with abort in IDLE -> both ignored; busy timing is unchanged.
